// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame and writes
// it word by word into instruction memory, holding the CPU in reset until it is valid.
module imem_loader #(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    localparam int          TW    = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_LEN_H, S_LEN_L, S_DATA, S_CHECK, S_RUN, S_ERROR
    } state_t;

    state_t            state, state_nx;
    logic [7:0]        len_hi;
    logic [15:0]       len_q;
    logic [15:0]       xor_acc;
    logic [23:0]       asm_q;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [TW-1:0]     idle_cnt;

    logic        accept;
    logic [15:0] len_in;
    logic        len_ok;
    logic        last_word;
    logic        timing;
    logic        timed_out;

    // Handshake: a byte moves exactly on a rising edge where rx_valid && rx_ready;
    // rx_ready depends only on state, never on rx_valid.
    always_comb begin
        rx_ready  = (state == S_LEN_H) || (state == S_LEN_L) ||
                    (state == S_DATA)  || (state == S_CHECK);
        accept    = rx_valid && rx_ready;
        len_in    = {len_hi, rx_data};
        len_ok    = (len_in != 16'd0) && ({1'b0, len_in} <= MAX_N);
        last_word = (16'(word_idx) + 16'd1) == len_q;
        timing    = (state == S_LEN_L) || (state == S_DATA) || (state == S_CHECK);
        timed_out = timing && !accept && ((idle_cnt + TW'(1)) == TW'(TIMEOUT));
        cpu_reset = (state != S_RUN);
        done      = (state == S_RUN);
        err       = (state == S_ERROR);
        state_dbg = state;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LEN_H: if (accept) state_nx = S_LEN_L;
            S_LEN_L: begin
                if (accept)         state_nx = len_ok ? S_DATA : S_ERROR;
                else if (timed_out) state_nx = S_ERROR;
            end
            S_DATA: begin
                if (accept && byte_cnt == 2'd3 && last_word) state_nx = S_CHECK;
                else if (timed_out)                          state_nx = S_ERROR;
            end
            S_CHECK: begin
                if (accept)         state_nx = ({8'h00, rx_data} == xor_acc) ? S_RUN : S_ERROR;
                else if (timed_out) state_nx = S_ERROR;
            end
            S_RUN:   state_nx = S_RUN;
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_LEN_H;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= S_LEN_H;
        else       state <= state_nx;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            len_hi   <= '0;
            len_q    <= '0;
            xor_acc  <= '0;
            asm_q    <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            idle_cnt <= '0;
            im_we    <= 1'b0;
            im_waddr <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= 1'b0;
            if (accept)      idle_cnt <= '0;
            else if (timing) idle_cnt <= idle_cnt + TW'(1);

            if (accept && state != S_CHECK) xor_acc <= xor_acc ^ {8'h00, rx_data};
            if (accept && state == S_LEN_H) len_hi <= rx_data;
            if (accept && state == S_LEN_L) len_q  <= len_in;

            if (accept && state == S_DATA) begin
                asm_q    <= {asm_q[15:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    im_we    <= 1'b1;
                    im_wdata <= {asm_q, rx_data};
                    im_waddr <= word_idx;
                    // Hold at the last index so a full-size image cannot wrap to 0.
                    if (!last_word) word_idx <= word_idx + ADDR_W'(1);
                end
            end
        end
    end

endmodule
